// File: rtl/up_timer_pkg.sv
// Shared definitions for the peripheral timer subsystem.
// Mode and state encodings are common to the up- and down-counting timers.
package up_timer_pkg;

    typedef enum logic [1:0] {
        MODE_FREE   = 2'b00,
        MODE_CYCLIC = 2'b01,
        MODE_SINGLE = 2'b10,
        MODE_RSVD   = 2'b11
    } timer_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } timer_state_e;

    localparam int TIMER_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/timer_irq_flag.sv
// Sticky interrupt and overrun flags with an acknowledge handshake.
// A new event always wins over a same-cycle acknowledge.
module timer_irq_flag (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic ack,
    output logic interrupt,
    output logic overrun
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            interrupt <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (set) begin
                interrupt <= 1'b1;
            end else if (ack) begin
                interrupt <= 1'b0;
            end

            // An event landing on an unacknowledged interrupt is lost; flag it.
            if (set && interrupt && !ack) begin
                overrun <= 1'b1;
            end else if (ack && !set && interrupt) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/up_timer.sv
// Programmable up-counting timer: free-running, cyclic or single-shot
// operation with a sticky interrupt and overrun flag.
module up_timer
    import up_timer_pkg::*;
#(
    parameter int WIDTH = TIMER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    input  logic             int_ack,
    output logic [WIDTH-1:0] count,
    output logic             interrupt,
    output logic             overrun,
    output logic             done
);

    timer_state_e     state;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] count_inc;
    logic             reached;
    logic             evt;

    assign count_inc = count + WIDTH'(1);
    // >= rather than == so that lowering the terminal below count still recovers.
    assign reached   = (count >= terminal);

    always_comb begin
        evt = 1'b0;
        if (state == RUN && start) begin
            case (timer_mode_e'(mode))
                MODE_FREE:   evt = (count == {WIDTH{1'b1}});
                MODE_CYCLIC: evt = reached;
                MODE_SINGLE: evt = reached;
                default:     evt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            terminal <= {WIDTH{1'b1}};
        end else if (load_en) begin
            terminal <= load_value;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= WIDTH'(1);
                    end
                end
                RUN: begin
                    if (start) begin
                        case (timer_mode_e'(mode))
                            MODE_FREE: count <= count_inc;
                            MODE_CYCLIC: begin
                                if (reached) count <= '0;
                                else         count <= count_inc;
                            end
                            MODE_SINGLE: begin
                                if (reached) begin
                                    done  <= 1'b1;
                                    state <= HALT;
                                end else begin
                                    count <= count_inc;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                HALT: begin
                    // Restart only after start has been released.
                    if (!start) begin
                        state <= IDLE;
                        count <= '0;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    timer_irq_flag u_irq_flag (
        .clk       (clk),
        .reset     (reset),
        .set       (evt),
        .ack       (int_ack),
        .interrupt (interrupt),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_up_timer.sv
// Directed bench for up_timer with hand-computed expected values.
module tb_up_timer;

    localparam int W = 16;

    logic         clk;
    logic         reset;
    logic [1:0]   mode;
    logic         start;
    logic         load_en;
    logic [W-1:0] load_value;
    logic         int_ack;
    logic [W-1:0] count;
    logic         interrupt;
    logic         overrun;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    up_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode       (mode),
        .start      (start),
        .load_en    (load_en),
        .load_value (load_value),
        .int_ack    (int_ack),
        .count      (count),
        .interrupt  (interrupt),
        .overrun    (overrun),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; pulses reset between edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic load_term(input logic [W-1:0] v);
        load_en    = 1'b1;
        load_value = v;
        tick();
        load_en    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; start = 1'b0;
        load_en = 1'b0; load_value = '0; int_ack = 1'b0;
        #12 reset = 1'b0;

        // Reset values
        chk("rst_count", 32'(count), 0);
        chk("rst_int", 32'(interrupt), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_done", 32'(done), 0);

        // 1: cyclic, terminal 5
        load_term(16'd5);
        mode = 2'b01; start = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("cyc_count", 32'(count), 32'(i));
            chk("cyc_int_low", 32'(interrupt), 0);
        end
        tick();
        chk("cyc_wrap_count", 32'(count), 0);
        chk("cyc_wrap_int", 32'(interrupt), 1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("cyc_ack_count", 32'(count), 1);
        chk("cyc_ack_int", 32'(interrupt), 0);

        // 2: single shot, terminal 3
        start = 1'b0;
        pulse_reset();
        load_term(16'd3);
        mode = 2'b10; start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("single_count", 32'(count), 32'(i));
            chk("single_done_low", 32'(done), 0);
        end
        tick();
        chk("single_hold", 32'(count), 3);
        chk("single_done", 32'(done), 1);
        chk("single_int", 32'(interrupt), 1);
        tick();
        chk("halt_hold", 32'(count), 3);
        chk("halt_done", 32'(done), 1);
        start = 1'b0;
        tick();
        chk("halt_exit_count", 32'(count), 0);
        chk("halt_exit_done", 32'(done), 0);
        start = 1'b1;
        tick();
        chk("restart_count", 32'(count), 1);
        tick();
        chk("restart_count2", 32'(count), 2);

        // 3: free running wrap, terminal ignored
        start = 1'b0;
        pulse_reset();
        load_term(16'd3);
        mode = 2'b00; start = 1'b1;
        repeat (65534) tick();
        chk("free_fffe", 32'(count), 32'hFFFE);
        chk("free_no_int", 32'(interrupt), 0);
        tick();
        chk("free_ffff", 32'(count), 32'hFFFF);
        chk("free_ffff_int", 32'(interrupt), 0);
        tick();
        chk("free_wrap", 32'(count), 0);
        chk("free_wrap_int", 32'(interrupt), 1);

        // 4: overrun and set-wins-over-ack
        start = 1'b0;
        pulse_reset();
        load_term(16'd2);
        mode = 2'b01; start = 1'b1;
        repeat (3) tick();
        chk("ovr_ev1_count", 32'(count), 0);
        chk("ovr_ev1_int", 32'(interrupt), 1);
        chk("ovr_ev1_ovr", 32'(overrun), 0);
        repeat (3) tick();
        chk("ovr_ev2_count", 32'(count), 0);
        chk("ovr_ev2_ovr", 32'(overrun), 1);
        repeat (2) tick();
        chk("ovr_pre_count", 32'(count), 2);
        int_ack = 1'b1;
        tick();
        chk("same_cyc_count", 32'(count), 0);
        chk("same_cyc_int", 32'(interrupt), 1);
        chk("same_cyc_ovr", 32'(overrun), 1);
        tick();
        int_ack = 1'b0;
        chk("ack_clr_int", 32'(interrupt), 0);
        chk("ack_clr_ovr", 32'(overrun), 0);

        // 5: lower terminal below count, then pause
        start = 1'b0;
        pulse_reset();
        mode = 2'b01; start = 1'b1;
        repeat (10) tick();
        chk("lower_pre", 32'(count), 10);
        start = 1'b0;
        load_term(16'd4);
        chk("lower_paused", 32'(count), 10);
        start = 1'b1;
        tick();
        chk("lower_wrap", 32'(count), 0);
        chk("lower_int", 32'(interrupt), 1);
        repeat (2) tick();
        chk("pause_pre", 32'(count), 2);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pause_hold", 32'(count), 2);
        end
        start = 1'b1;
        tick();
        chk("pause_resume", 32'(count), 3);

        // 6: async reset mid-run, reserved mode, terminal restored
        start = 1'b0;
        pulse_reset();
        load_term(16'd4);
        mode = 2'b01; start = 1'b1;
        repeat (10) tick();
        chk("pre_rst_count", 32'(count), 0);
        chk("pre_rst_ovr", 32'(overrun), 1);
        tick();
        chk("pre_rst_count2", 32'(count), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_int", 32'(interrupt), 0);
        chk("async_ovr", 32'(overrun), 0);
        chk("async_done", 32'(done), 0);
        mode = 2'b11;
        #1 reset = 1'b0;
        tick();
        chk("rsvd_first", 32'(count), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsvd_hold", 32'(count), 1);
            chk("rsvd_no_int", 32'(interrupt), 0);
        end
        mode = 2'b01;
        repeat (5) tick();
        chk("term_restored_count", 32'(count), 6);
        chk("term_restored_int", 32'(interrupt), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
